// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: requester-side control for an iterative unsigned divider (DIV/DIVU/REM/REMU).
// Latency: 2 cycles req->done_o for div-by-zero/overflow/illegal; ISSUE + core + FIXUP + DONE otherwise.
// Backpressure: busy_o stalls the CPU; start is held off while div_busy_i; req_i ignored outside IDLE.
// Option: define DIV_REM_EN to support REM/REMU; without it they complete with err_o=1, result 0.
module div_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             dz_o,
  output logic             err_o,
  output logic             div_start_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic             div_busy_i,
  input  logic             div_valid_i,
  input  logic             div_error_i,
  input  logic [WIDTH-1:0] div_result_i
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIXUP, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             r_rem, r_qneg, r_rneg, r_dz, r_ovf, r_err;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_q, r_result;
  logic [CW-1:0]    r_tmo;

  // Operand decode at the request boundary
  logic             w_signed, w_s1, w_s2, w_dz_in, w_ovf_in, w_ill_in, w_tmo_hit;
  logic [WIDTH-1:0] w_abs1, w_abs2, w_qfix, w_rs1_orig, w_fix_result;

  assign w_signed  = ~op_i[0];
  assign w_s1      = w_signed & rs1_i[WIDTH-1];
  assign w_s2      = w_signed & rs2_i[WIDTH-1];
  assign w_abs1    = w_s1 ? -rs1_i : rs1_i;
  assign w_abs2    = w_s2 ? -rs2_i : rs2_i;
  assign w_dz_in   = (rs2_i == '0);
  assign w_ovf_in  = w_signed && (rs1_i == MIN_VAL) && (rs2_i == '1);
`ifdef DIV_REM_EN
  assign w_ill_in  = 1'b0;
`else
  assign w_ill_in  = op_i[1];
`endif
  assign w_tmo_hit = (r_tmo == CW'(TIMEOUT_CYC - 1));

  // Sign fix-up of the unsigned core result; original rs1 rebuilt from magnitude and sign
  assign w_qfix     = r_qneg ? -r_q : r_q;
  assign w_rs1_orig = r_rneg ? -r_dvd : r_dvd;

`ifdef DIV_REM_EN
  logic [WIDTH-1:0] w_prod, w_r, w_rfix;
  assign w_prod = r_q * r_dvs;
  assign w_r    = r_dvd - w_prod;
  assign w_rfix = r_rneg ? -w_r : w_r;
`endif

  // Final result selection: illegal, divide-by-zero, overflow, then normal quotient/remainder
  always_comb begin
    w_fix_result = '0;
    if (r_err)      w_fix_result = '0;
    else if (r_dz)  w_fix_result = r_rem ? w_rs1_orig : '1;
    else if (r_ovf) w_fix_result = r_rem ? '0 : MIN_VAL;
`ifdef DIV_REM_EN
    else            w_fix_result = r_rem ? w_rfix : w_qfix;
`else
    else            w_fix_result = w_qfix;
`endif
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs; special cases skip the core and resolve in FIXUP
  always_comb begin
    w_next      = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    div_start_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) w_next = (w_dz_in || w_ovf_in || w_ill_in) ? S_FIXUP : S_ISSUE;
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (!div_busy_i) begin
          div_start_o = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (div_error_i)      w_next = S_DONE;
        else if (div_valid_i) w_next = S_FIXUP;
        else if (w_tmo_hit)   w_next = S_DONE;
      end
      S_FIXUP: begin
        busy_o = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, timeout counting, core result capture and result update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem    <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_q      <= '0;
      r_result <= '0;
      r_tmo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_rem  <= op_i[1];
            r_qneg <= w_s1 ^ w_s2;
            r_rneg <= w_s1;
            r_dvd  <= w_abs1;
            r_dvs  <= w_abs2;
            r_dz   <= w_dz_in & ~w_ill_in;
            r_ovf  <= w_ovf_in & ~w_ill_in;
            r_err  <= w_ill_in;
            r_tmo  <= '0;
          end
        end
        S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (div_error_i || (!div_valid_i && w_tmo_hit)) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else if (div_valid_i) begin
            r_q <= div_result_i;
          end
        end
        S_FIXUP: r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

  assign result_o       = r_result;
  assign dz_o           = done_o & r_dz;
  assign err_o          = done_o & r_err;
  assign div_dividend_o = r_dvd;
  assign div_divisor_o  = r_dvs;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized and directed bench for div_issue_ctrl with a behavioural divider core.
// Expected results come from plain signed/unsigned SV arithmetic plus the special-case rules.
// The core model answers WIDTH+2 cycles after a start, or never answers in hang mode.
module tb_div_issue_ctrl;
  localparam int W    = 32;
  localparam int TMO  = 64;
  localparam int CLAT = W + 2;
  localparam int LAT_NORM = 3 + CLAT;
  localparam int LAT_SPEC = 2;
  localparam int LAT_TMO  = 2 + TMO;

  logic          clk_i = 1'b0, rst_i = 1'b1, req_i = 1'b0;
  logic [1:0]    op_i = '0;
  logic [W-1:0]  rs1_i = '0, rs2_i = '0;
  logic          busy_o, done_o, dz_o, err_o, div_start_o;
  logic [W-1:0]  result_o, div_dividend_o, div_divisor_o;
  logic          div_busy_i = 1'b0, div_valid_i = 1'b0, div_error_i = 1'b0;
  logic [W-1:0]  div_result_i = '0;

  int checks = 0;
  int errors = 0;
  bit stub_hang = 1'b0;

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .dz_o(dz_o), .err_o(err_o),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_busy_i(div_busy_i), .div_valid_i(div_valid_i), .div_error_i(div_error_i),
    .div_result_i(div_result_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural unsigned divider core sharing the reset
  int           stub_cnt;
  logic [W-1:0] stub_a, stub_b;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_busy_i  <= 1'b0;
      div_valid_i <= 1'b0;
      stub_cnt    <= 0;
    end else begin
      div_valid_i <= 1'b0;
      if (div_start_o && !div_busy_i) begin
        div_busy_i <= 1'b1;
        stub_cnt   <= CLAT - 1;
        stub_a     <= div_dividend_o;
        stub_b     <= div_divisor_o;
      end else if (div_busy_i) begin
        if (stub_cnt == 1) begin
          div_busy_i <= 1'b0;
          stub_cnt   <= 0;
          if (!stub_hang) begin
            div_valid_i  <= 1'b1;
            div_result_i <= (stub_b == 0) ? '1 : stub_a / stub_b;
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic dz, output logic err,
                                output logic special);
    logic signed [W-1:0] sa, sb;
    sa = a; sb = b;
    dz = 1'b0; err = 1'b0; special = 1'b0; res = '0;
`ifndef DIV_REM_EN
    if (op[1]) begin
      err = 1'b1; special = 1'b1; res = '0;
      return;
    end
`endif
    if (b == 0) begin
      dz = 1'b1; special = 1'b1;
      res = op[1] ? a : '1;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      special = 1'b1;
      res = op[1] ? '0 : 32'h8000_0000;
    end else begin
      case (op)
        2'd0:    res = sa / sb;
        2'd1:    res = a / b;
        2'd2:    res = sa % sb;
        default: res = a % b;
      endcase
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hang, input string tag);
    logic [W-1:0] eres;
    logic edz, eerr, espec;
    int elat, n, starts, busy_cyc, viol, estarts;
    logic prev;
    bit seen;
    model(op, a, b, eres, edz, eerr, espec);
    if (hang) begin
      eres = '0; edz = 1'b0; eerr = 1'b1; elat = LAT_TMO; estarts = 1;
    end else begin
      elat = espec ? LAT_SPEC : LAT_NORM;
      estarts = espec ? 0 : 1;
    end
    stub_hang = hang;
    @(negedge clk_i);
    req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    n = 0; starts = 0; busy_cyc = 0; viol = 0; prev = 1'b0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk_i);
      n++;
      if (div_start_o) begin
        starts++;
        if (div_busy_i) viol++;
        if (prev) viol++;
      end
      prev = div_start_o;
      if (busy_o) busy_cyc++;
      if (done_o) seen = 1'b1;
      // Garbage on the request port while busy and during DONE must be ignored
      req_i = 1'($urandom); op_i = 2'($urandom); rs1_i = $urandom; rs2_i = $urandom;
      if (done_o) req_i = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_result"}, result_o, eres);
    check({tag, "_dz"}, 32'(dz_o), 32'(edz));
    check({tag, "_err"}, 32'(err_o), 32'(eerr));
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_starts"}, 32'(starts), 32'(estarts));
    check({tag, "_start_protocol"}, 32'(viol), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(elat - 1));
    @(negedge clk_i);
    check({tag, "_done_once"}, 32'(done_o), 32'd0);
    check({tag, "_idle_after"}, 32'(busy_o), 32'd0);
    req_i = 1'b0;
    stub_hang = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'(0) - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_start", 32'(div_start_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_dz_err", 32'({dz_o, err_o}), 32'd0);
    check("rst_dividend", div_dividend_o, 32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    run_op(2'd1, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
    run_op(2'd0, 32'd5, 32'd0, 1'b0, "div_5_0");
    run_op(2'd3, 32'd5, 32'd0, 1'b0, "remu_5_0");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_min_ff");
    run_op(2'd3, 32'd17, 32'hFFFF_FFFB, 1'b0, "remu_17_big");

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, $sformatf("rnd%0d", i));
    end

    run_op(2'd1, 32'd1000, 32'd3, 1'b1, "timeout");
    run_op(2'd1, 32'd100, 32'd7, 1'b0, "post_timeout");

    // Reset while waiting on the core
    @(negedge clk_i);
    req_i = 1'b1; op_i = 2'd1; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("midwait_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_start", 32'(div_start_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_operands", div_dividend_o | div_divisor_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_no_stale_done", 32'(done_o), 32'd0);
    run_op(2'd1, 32'd9, 32'd3, 1'b0, "divu_9_3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
